// File: rtl/bc_turn_controller.sv
// Bulls & Cows game sequencer: secret entry for both players, alternating guesses,
// distinct-digit entry validation and a serial one-digit-per-cycle bulls/cows scorer.
module bc_turn_controller #(
   parameter bit DECIMAL_ONLY = 1'b0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        confirma,
   input  logic [15:0] SW,
   output logic [2:0]  phase,
   output logic        player,
   output logic [2:0]  bulls,
   output logic [2:0]  cows,
   output logic        result_valid,
   output logic        reject,
   output logic        win,
   output logic        winner
);

   typedef enum logic [2:0] {
      P1SETUP = 3'd0,
      P2SETUP = 3'd1,
      GUESS   = 3'd2,
      CHECK   = 3'd3,
      SCORE   = 3'd4,
      RESULT  = 3'd5,
      WIN     = 3'd6
   } state_t;

   state_t      state, origin;
   logic [15:0] cand, secret1, secret2, guess;
   logic [1:0]  idx;
   logic [15:0] target;
   logic [3:0]  guess_digit;
   logic        is_bull, is_cow, cand_ok;

   // Digit 0 is the most significant nibble, matching the switch layout.
   function automatic logic [3:0] digit(input logic [15:0] v, input logic [1:0] i);
      case (i)
         2'd0:    return v[15:12];
         2'd1:    return v[11:8];
         2'd2:    return v[7:4];
         default: return v[3:0];
      endcase
   endfunction

   function automatic logic entry_ok(input logic [15:0] v);
      logic ok;
      ok = 1'b1;
      for (int a = 0; a < 4; a++) begin
         if (DECIMAL_ONLY && (digit(v, 2'(a)) > 4'd9)) ok = 1'b0;
         for (int b = a + 1; b < 4; b++)
            if (digit(v, 2'(a)) == digit(v, 2'(b))) ok = 1'b0;
      end
      return ok;
   endfunction

   // NOTE: every signal gets an unconditional assignment before any conditional one,
   // so no path leaves a value held and no latch is inferred.
   always_comb begin
      cand_ok     = entry_ok(cand);
      target      = player ? secret1 : secret2;
      guess_digit = digit(guess, idx);
      is_bull     = (guess_digit == digit(target, idx));
      is_cow      = 1'b0;
      for (int j = 0; j < 4; j++)
         if ((2'(j) != idx) && (guess_digit == digit(target, 2'(j)))) is_cow = 1'b1;
   end

   // NOTE: state registers use non-blocking assignments so all flops update together
   // from values sampled before the edge, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= P1SETUP;
         origin       <= P1SETUP;
         cand         <= '0;
         secret1      <= '0;
         secret2      <= '0;
         guess        <= '0;
         idx          <= '0;
         player       <= 1'b0;
         bulls        <= '0;
         cows         <= '0;
         result_valid <= 1'b0;
         reject       <= 1'b0;
         win          <= 1'b0;
         winner       <= 1'b0;
      end else begin
         reject <= 1'b0;
         case (state)
            P1SETUP, P2SETUP, GUESS: begin
               if (confirma) begin
                  cand   <= SW;
                  origin <= state;
                  state  <= CHECK;
               end
            end
            CHECK: begin
               if (!cand_ok) begin
                  state  <= origin;
                  reject <= 1'b1;
                  cand   <= '0;
               end else begin
                  case (origin)
                     P1SETUP: begin
                        secret1 <= cand;
                        state   <= P2SETUP;
                     end
                     P2SETUP: begin
                        secret2 <= cand;
                        player  <= 1'b0;
                        state   <= GUESS;
                     end
                     default: begin
                        guess <= cand;
                        idx   <= '0;
                        bulls <= '0;
                        cows  <= '0;
                        state <= SCORE;
                     end
                  endcase
               end
            end
            SCORE: begin
               if (is_bull)     bulls <= bulls + 3'd1;
               else if (is_cow) cows  <= cows + 3'd1;
               idx <= idx + 2'd1;
               if (idx == 2'd3) begin
                  state        <= RESULT;
                  result_valid <= 1'b1;
               end
            end
            RESULT: begin
               if (confirma) begin
                  result_valid <= 1'b0;
                  if (bulls == 3'd4) begin
                     winner <= player;
                     win    <= 1'b1;
                     state  <= WIN;
                  end else begin
                     player <= ~player;
                     state  <= GUESS;
                  end
               end
            end
            WIN: begin
               if (confirma) begin
                  secret1 <= '0;
                  secret2 <= '0;
                  player  <= 1'b0;
                  win     <= 1'b0;
                  bulls   <= '0;
                  cows    <= '0;
                  state   <= P1SETUP;
               end
            end
            default: state <= P1SETUP;
         endcase
      end
   end

   assign phase = state;

endmodule

// File: tb/tb_bc_turn_controller.sv
// Directed bench for bc_turn_controller: setup, rejection, scoring, win, ignored
// confirms and reset during scoring, with hand-computed expectations.
module tb_bc_turn_controller;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        confirma = 1'b0;
   logic [15:0] SW = 16'h0000;

   logic [2:0] phase, bulls, cows;
   logic       player, result_valid, reject, win, winner;
   logic [2:0] d_phase, d_bulls, d_cows;
   logic       d_player, d_result_valid, d_reject, d_win, d_winner;

   int total = 0;
   int bad   = 0;

   bc_turn_controller dut (
      .clock(clock), .reset(reset), .confirma(confirma), .SW(SW),
      .phase(phase), .player(player), .bulls(bulls), .cows(cows),
      .result_valid(result_valid), .reject(reject), .win(win), .winner(winner)
   );

   bc_turn_controller #(.DECIMAL_ONLY(1'b1)) dut_dec (
      .clock(clock), .reset(reset), .confirma(confirma), .SW(SW),
      .phase(d_phase), .player(d_player), .bulls(d_bulls), .cows(d_cows),
      .result_valid(d_result_valid), .reject(d_reject), .win(d_win), .winner(d_winner)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Confirm strobe for exactly one rising edge; returns in the cycle after that edge.
   task automatic press(input logic [15:0] value);
      SW       = value;
      confirma = 1'b1;
      tick(1);
      confirma = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_phase"},  16'(phase), 16'd0);
      check({tag, "_player"}, 16'(player), 16'd0);
      check({tag, "_bulls"},  16'(bulls), 16'd0);
      check({tag, "_cows"},   16'(cows), 16'd0);
      check({tag, "_rv"},     16'(result_valid), 16'd0);
      check({tag, "_reject"}, 16'(reject), 16'd0);
      check({tag, "_win"},    16'(win), 16'd0);
      check({tag, "_winner"}, 16'(winner), 16'd0);
   endtask

   // Guess entered in GUESS; returns in the first RESULT cycle (6 edges after confirm).
   task automatic guess_and_score(input logic [15:0] value);
      press(value);
      tick(5);
   endtask

   initial begin
      tick(1);
      do_reset();
      check_reset_outputs("rst");
      check("rst_dec_phase", 16'(d_phase), 16'd0);

      // Hex digit entry: accepted without DECIMAL_ONLY, rejected with it.
      press(16'h12A4);
      check("hex_check_phase", 16'(phase), 16'd3);
      tick(1);
      check("hex_dec0_phase",  16'(phase), 16'd1);
      check("hex_dec0_reject", 16'(reject), 16'd0);
      check("hex_dec1_phase",  16'(d_phase), 16'd0);
      check("hex_dec1_reject", 16'(d_reject), 16'd1);
      tick(1);
      check("hex_dec1_reject_drop", 16'(d_reject), 16'd0);

      // Repeated digit is rejected for exactly one cycle.
      do_reset();
      press(16'h1123);
      check("dup_check_phase", 16'(phase), 16'd3);
      tick(1);
      check("dup_phase",  16'(phase), 16'd0);
      check("dup_reject", 16'(reject), 16'd1);
      tick(1);
      check("dup_reject_drop", 16'(reject), 16'd0);
      check("dup_phase_hold",  16'(phase), 16'd0);

      // Setup sequence.
      press(16'h1234);
      check("s1_check", 16'(phase), 16'd3);
      tick(1);
      check("s1_phase",  16'(phase), 16'd1);
      check("s1_reject", 16'(reject), 16'd0);
      press(16'h5678);
      check("s2_check", 16'(phase), 16'd3);
      tick(1);
      check("s2_phase",  16'(phase), 16'd2);
      check("s2_player", 16'(player), 16'd0);
      check("s2_reject", 16'(reject), 16'd0);

      // P1 guess 5687 vs 5678 with confirm held through CHECK and all SCORE cycles;
      // SW changes after the confirm edge must not matter.
      SW       = 16'h5687;
      confirma = 1'b1;
      tick(1);
      check("g1_check", 16'(phase), 16'd3);
      SW = 16'h0000;
      tick(1);
      check("g1_score0", 16'(phase), 16'd4);
      tick(3);
      check("g1_score3", 16'(phase), 16'd4);
      check("g1_rv_early", 16'(result_valid), 16'd0);
      tick(1);
      confirma = 1'b0;
      check("g1_phase", 16'(phase), 16'd5);
      check("g1_rv",    16'(result_valid), 16'd1);
      check("g1_bulls", 16'(bulls), 16'd2);
      check("g1_cows",  16'(cows), 16'd2);
      tick(2);
      check("g1_hold_phase", 16'(phase), 16'd5);
      check("g1_hold_bulls", 16'(bulls), 16'd2);
      check("g1_hold_cows",  16'(cows), 16'd2);
      press(16'h0000);
      check("g1_next_phase",  16'(phase), 16'd2);
      check("g1_next_player", 16'(player), 16'd1);
      check("g1_next_rv",     16'(result_valid), 16'd0);

      // P2 guess 9ABC vs 1234: nothing matches.
      guess_and_score(16'h9ABC);
      check("g2_phase", 16'(phase), 16'd5);
      check("g2_bulls", 16'(bulls), 16'd0);
      check("g2_cows",  16'(cows), 16'd0);
      press(16'h0000);
      check("g2_next_player", 16'(player), 16'd0);

      // P1 guess 8765 vs 5678: all cows.
      guess_and_score(16'h8765);
      check("g3_bulls", 16'(bulls), 16'd0);
      check("g3_cows",  16'(cows), 16'd4);
      press(16'h0000);
      check("g3_next_player", 16'(player), 16'd1);

      // P2 guess 1234 vs 1234: win.
      guess_and_score(16'h1234);
      check("g4_bulls", 16'(bulls), 16'd4);
      check("g4_cows",  16'(cows), 16'd0);
      press(16'h0000);
      check("win_phase",  16'(phase), 16'd6);
      check("win_win",    16'(win), 16'd1);
      check("win_winner", 16'(winner), 16'd1);
      check("win_rv",     16'(result_valid), 16'd0);
      press(16'h0000);
      check("restart_phase",  16'(phase), 16'd0);
      check("restart_win",    16'(win), 16'd0);
      check("restart_player", 16'(player), 16'd0);
      check("restart_bulls",  16'(bulls), 16'd0);

      // Reset together with confirm during SCORE.
      press(16'h1234);
      tick(1);
      press(16'h5678);
      tick(1);
      press(16'h5687);
      tick(2);
      check("mid_in_score", 16'(phase), 16'd4);
      reset    = 1'b1;
      confirma = 1'b1;
      tick(1);
      reset    = 1'b0;
      confirma = 1'b0;
      check_reset_outputs("mid_rst");
      press(16'h5678);
      tick(1);
      check("mid_reenter_phase", 16'(phase), 16'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
